// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
//
// ID/EX pipeline register for the forwarding MIPS pipeline. Each rising edge
// either LOADs the decoded ID instruction (operands, fields, forwarding
// selects) into the EX slot, or inserts a BUBBLE: all EX fields are cleared
// and ex_valid drops. Two saturating counters record stall-induced bubbles
// and valid instructions killed by a flush.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   stall                 load-use stall from the conflict detector
//   flush                 taken branch/jump resolved in EX; kills ID
//   id_valid              ID slot holds a real instruction
//   id_pc, id_imm         PC and extended immediate (DW bits)
//   id_op, id_funct       opcode / function fields (6 bits)
//   id_rs/rt/rd/shamt     register and shift fields (5 bits)
//   id_rf_a, id_rf_b      register-file read data (DW bits)
//   id_fwd_a, id_fwd_b    operand source selects (00 RF, 01 EX, 10 MEM)
//   ex_*                  registered copies of the id_* inputs, ex_valid
//   bubble_cnt            saturating count of stall bubbles (CW bits)
//   flush_cnt             saturating count of flushed valid instructions
// -----------------------------------------------------------------------------
module id_ex_reg #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [DW-1:0] id_pc,
    input  logic [5:0]    id_op,
    input  logic [5:0]    id_funct,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic [4:0]    id_shamt,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_rf_a,
    input  logic [DW-1:0] id_rf_b,
    input  logic [1:0]    id_fwd_a,
    input  logic [1:0]    id_fwd_b,
    output logic          ex_valid,
    output logic [DW-1:0] ex_pc,
    output logic [5:0]    ex_op,
    output logic [5:0]    ex_funct,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_rd,
    output logic [4:0]    ex_shamt,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_rf_a,
    output logic [DW-1:0] ex_rf_b,
    output logic [1:0]    ex_fwd_a,
    output logic [1:0]    ex_fwd_b,
    output logic [CW-1:0] bubble_cnt,
    output logic [CW-1:0] flush_cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          valid_q,  valid_d;
    logic [DW-1:0] pc_q,     pc_d;
    logic [5:0]    op_q,     op_d;
    logic [5:0]    funct_q,  funct_d;
    logic [4:0]    rs_q,     rs_d;
    logic [4:0]    rt_q,     rt_d;
    logic [4:0]    rd_q,     rd_d;
    logic [4:0]    shamt_q,  shamt_d;
    logic [DW-1:0] imm_q,    imm_d;
    logic [DW-1:0] rf_a_q,   rf_a_d;
    logic [DW-1:0] rf_b_q,   rf_b_d;
    logic [1:0]    fwd_a_q,  fwd_a_d;
    logic [1:0]    fwd_b_q,  fwd_b_d;
    logic [CW-1:0] bub_q,    bub_d;
    logic [CW-1:0] fl_q,     fl_d;

    logic load;
    logic bub_inc;
    logic fl_inc;

    // flush outranks stall, which outranks an empty ID slot
    assign load    = !flush && !stall && id_valid;
    // a flush during a stall is counted only as a flush
    assign bub_inc = stall && !flush;
    assign fl_inc  = flush && id_valid;

    always_comb begin
        // bubble by default: every field zero so a bubble never matches a
        // source register in the hazard detector and never looks like a load
        valid_d = 1'b0;
        pc_d    = '0;
        op_d    = '0;
        funct_d = '0;
        rs_d    = '0;
        rt_d    = '0;
        rd_d    = '0;
        shamt_d = '0;
        imm_d   = '0;
        rf_a_d  = '0;
        rf_b_d  = '0;
        fwd_a_d = '0;
        fwd_b_d = '0;
        if (load) begin
            valid_d = 1'b1;
            pc_d    = id_pc;
            op_d    = id_op;
            funct_d = id_funct;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
            shamt_d = id_shamt;
            imm_d   = id_imm;
            rf_a_d  = id_rf_a;
            rf_b_d  = id_rf_b;
            // reserved select 11 falls back to the register file
            fwd_a_d = (id_fwd_a == 2'b11) ? 2'b00 : id_fwd_a;
            fwd_b_d = (id_fwd_b == 2'b11) ? 2'b00 : id_fwd_b;
        end

        bub_d = bub_q;
        if (bub_inc && (bub_q != CNT_MAX)) begin
            bub_d = bub_q + 1'b1;
        end
        fl_d = fl_q;
        if (fl_inc && (fl_q != CNT_MAX)) begin
            fl_d = fl_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            op_q    <= '0;
            funct_q <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            shamt_q <= '0;
            imm_q   <= '0;
            rf_a_q  <= '0;
            rf_b_q  <= '0;
            fwd_a_q <= '0;
            fwd_b_q <= '0;
            bub_q   <= '0;
            fl_q    <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            funct_q <= funct_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            shamt_q <= shamt_d;
            imm_q   <= imm_d;
            rf_a_q  <= rf_a_d;
            rf_b_q  <= rf_b_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            bub_q   <= bub_d;
            fl_q    <= fl_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_pc      = pc_q;
    assign ex_op      = op_q;
    assign ex_funct   = funct_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_rd      = rd_q;
    assign ex_shamt   = shamt_q;
    assign ex_imm     = imm_q;
    assign ex_rf_a    = rf_a_q;
    assign ex_rf_b    = rf_b_q;
    assign ex_fwd_a   = fwd_a_q;
    assign ex_fwd_b   = fwd_b_q;
    assign bubble_cnt = bub_q;
    assign flush_cnt  = fl_q;

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, flush, id_valid;
    logic [DW-1:0] id_pc, id_imm, id_rf_a, id_rf_b;
    logic [5:0]    id_op, id_funct;
    logic [4:0]    id_rs, id_rt, id_rd, id_shamt;
    logic [1:0]    id_fwd_a, id_fwd_b;
    logic          ex_valid;
    logic [DW-1:0] ex_pc, ex_imm, ex_rf_a, ex_rf_b;
    logic [5:0]    ex_op, ex_funct;
    logic [4:0]    ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [1:0]    ex_fwd_a, ex_fwd_b;
    logic [CW-1:0] bubble_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    id_ex_reg #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_op(id_op), .id_funct(id_funct), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt), .id_imm(id_imm),
        .id_rf_a(id_rf_a), .id_rf_b(id_rf_b), .id_fwd_a(id_fwd_a), .id_fwd_b(id_fwd_b),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op), .ex_funct(ex_funct),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
        .ex_imm(ex_imm), .ex_rf_a(ex_rf_a), .ex_rf_b(ex_rf_b),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // every ex_* field must be zero (bubble or reset)
    task automatic chk_slot_zero(input string tag);
        chk({tag, ".valid"}, 64'(ex_valid), 64'd0);
        chk({tag, ".pc"},    64'(ex_pc),    64'd0);
        chk({tag, ".op"},    64'(ex_op),    64'd0);
        chk({tag, ".funct"}, 64'(ex_funct), 64'd0);
        chk({tag, ".rs"},    64'(ex_rs),    64'd0);
        chk({tag, ".rt"},    64'(ex_rt),    64'd0);
        chk({tag, ".rd"},    64'(ex_rd),    64'd0);
        chk({tag, ".shamt"}, 64'(ex_shamt), 64'd0);
        chk({tag, ".imm"},   64'(ex_imm),   64'd0);
        chk({tag, ".rf_a"},  64'(ex_rf_a),  64'd0);
        chk({tag, ".rf_b"},  64'(ex_rf_b),  64'd0);
        chk({tag, ".fwd_a"}, 64'(ex_fwd_a), 64'd0);
        chk({tag, ".fwd_b"}, 64'(ex_fwd_b), 64'd0);
    endtask

    task automatic chk_cnt(input string tag, input int bub, input int fl);
        chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(bub));
        chk({tag, ".flush_cnt"},  64'(flush_cnt),  64'(fl));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] pc, input logic [5:0] op,
                         input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [DW-1:0] imm,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [1:0] fa, input logic [1:0] fb);
        id_valid = v; id_pc = pc; id_op = op; id_funct = fn; id_rs = rs; id_rt = rt;
        id_rd = rd; id_shamt = sh; id_imm = imm; id_rf_a = a; id_rf_b = b;
        id_fwd_a = fa; id_fwd_b = fb;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        tick(); tick();
        rst = 1'b0;

        // load something nonzero, then assert reset between edges
        drive(1'b1, 32'h40, 6'h08, 6'h00, 5'd3, 5'd4, 5'd0, 5'd0, 32'h10, 32'h11, 32'h12, 2'b10, 2'b01);
        tick();
        chk("pre_rst.valid", 64'(ex_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk_slot_zero("async_rst");
        chk_cnt("async_rst", 0, 0);
        #1 rst = 1'b0;

        // add r8 = r17 + r17, fwd_a from EX; first edge after reset must load
        drive(1'b1, 32'h100, 6'h00, 6'h20, 5'd17, 5'd17, 5'd8, 5'd0, 32'h0, 32'd5, 32'd7, 2'b01, 2'b00);
        tick();
        chk("load.valid", 64'(ex_valid), 64'd1);
        chk("load.funct", 64'(ex_funct), 64'h20);
        chk("load.rs",    64'(ex_rs),    64'd17);
        chk("load.rt",    64'(ex_rt),    64'd17);
        chk("load.rd",    64'(ex_rd),    64'd8);
        chk("load.rf_a",  64'(ex_rf_a),  64'd5);
        chk("load.rf_b",  64'(ex_rf_b),  64'd7);
        chk("load.fwd_a", 64'(ex_fwd_a), 64'd1);
        chk("load.pc",    64'(ex_pc),    64'h100);
        chk_cnt("load", 0, 0);

        // lw r17, 4(r2)
        drive(1'b1, 32'h104, 6'h23, 6'h00, 5'd2, 5'd17, 5'd0, 5'd0, 32'd4, 32'h200, 32'h0, 2'b00, 2'b00);
        tick();
        chk("lw.op",  64'(ex_op),  64'h23);
        chk("lw.rt",  64'(ex_rt),  64'd17);
        chk("lw.imm", 64'(ex_imm), 64'd4);

        // dependent add in ID, load-use stall for one cycle
        drive(1'b1, 32'h108, 6'h00, 6'h20, 5'd17, 5'd9, 5'd10, 5'd3, 32'h0, 32'd1, 32'd2, 2'b00, 2'b00);
        stall = 1'b1;
        tick();
        chk_slot_zero("stall");
        chk_cnt("stall", 1, 0);

        stall = 1'b0;
        drive(1'b1, 32'h108, 6'h00, 6'h20, 5'd17, 5'd9, 5'd10, 5'd3, 32'h0, 32'd1, 32'd2, 2'b10, 2'b00);
        tick();
        chk("resume.valid", 64'(ex_valid), 64'd1);
        chk("resume.pc",    64'(ex_pc),    64'h108);
        chk("resume.rs",    64'(ex_rs),    64'd17);
        chk("resume.shamt", 64'(ex_shamt), 64'd3);
        chk("resume.fwd_a", 64'(ex_fwd_a), 64'd2);
        chk_cnt("resume", 1, 0);

        // stall and flush together: flush wins, bubble_cnt unchanged
        stall = 1'b1; flush = 1'b1;
        tick();
        chk_slot_zero("stall_flush");
        chk_cnt("stall_flush", 1, 1);

        // flush alone with an empty ID slot: no count
        stall = 1'b0; flush = 1'b1; id_valid = 1'b0;
        tick();
        chk("flush_inv.valid", 64'(ex_valid), 64'd0);
        chk_cnt("flush_inv", 1, 1);

        // invalid ID slot with nonzero fields
        flush = 1'b0;
        drive(1'b0, 32'h1FC, 6'h23, 6'h2A, 5'd31, 5'd30, 5'd29, 5'd28, 32'hDEAD, 32'hBEEF, 32'hCAFE, 2'b01, 2'b10);
        tick();
        chk_slot_zero("invalid");
        chk_cnt("invalid", 1, 1);

        // reserved select 11 normalises to 00
        drive(1'b1, 32'h10C, 6'h00, 6'h22, 5'd4, 5'd5, 5'd6, 5'd0, 32'h0, 32'd9, 32'd3, 2'b11, 2'b11);
        tick();
        chk("norm.valid", 64'(ex_valid), 64'd1);
        chk("norm.fwd_a", 64'(ex_fwd_a), 64'd0);
        chk("norm.fwd_b", 64'(ex_fwd_b), 64'd0);
        drive(1'b1, 32'h110, 6'h00, 6'h22, 5'd4, 5'd5, 5'd6, 5'd0, 32'h0, 32'd9, 32'd3, 2'b00, 2'b10);
        tick();
        chk("fwd_b_mem", 64'(ex_fwd_b), 64'd2);

        // 20 stall cycles, counter saturates at 15 (starts at 1)
        stall = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        chk("sat.bubble_14", 64'(bubble_cnt), 64'd14);
        for (int i = 0; i < 7; i++) tick();
        chk("sat.bubble_15", 64'(bubble_cnt), 64'd15);
        tick();
        chk("sat.bubble_hold", 64'(bubble_cnt), 64'd15);
        chk("sat.flush_same", 64'(flush_cnt), 64'd1);

        // 20 valid flushes, flush counter saturates too
        stall = 1'b0; flush = 1'b1; id_valid = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        chk("sat.flush_14", 64'(flush_cnt), 64'd14);
        for (int i = 0; i < 7; i++) tick();
        chk_cnt("sat.flush_hold", 15, 15);
        flush = 1'b0;

        // mid-stream reset with ex_valid=1 and bubble_cnt=3
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        chk_cnt("clear", 0, 0);
        stall = 1'b1;
        tick(); tick(); tick();
        stall = 1'b0;
        drive(1'b1, 32'h200, 6'h0D, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 32'hFF, 32'd6, 32'd0, 2'b01, 2'b01);
        tick();
        chk("mid.valid", 64'(ex_valid), 64'd1);
        chk("mid.op",    64'(ex_op),    64'h0D);
        chk_cnt("mid", 3, 0);
        #2 rst = 1'b1;
        #1;
        chk_slot_zero("mid_rst");
        chk_cnt("mid_rst", 0, 0);
        #1 rst = 1'b0;
        tick();
        chk("post_rst.valid", 64'(ex_valid), 64'd1);
        chk("post_rst.imm",   64'(ex_imm),   64'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
